// File: rtl/dice_face_decoder.sv
// dice_face_decoder
//   Receive side of the dice roller LED bus. The 6-bit face pattern is
//   filtered for stability, and each newly settled pattern is decoded into a
//   face value 1-6 or flagged as illegal. Each event is offered on a
//   single-entry valid/ready output register. Saturating per-face and error
//   histograms can be read back for statistics.
//
// Parameters
//   STABLE_CYCLES : consecutive sampling edges a pattern must hold (2..255)
//   CNT_W         : width of every histogram / error counter
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   led_in     in   [5:0] face pattern from the roller
//   out_ready  in   consumer takes the held event this cycle
//   clear      in   synchronous clear of histograms, err_count and overrun
//   hist_sel   in   [2:0] 0 = err_count, 1..6 = face counter, 7 = zero
//   out_valid  out  an event is held
//   out_value  out  [2:0] decoded face 1..6, 0 for an error event
//   out_error  out  held event is an illegal pattern
//   overrun    out  sticky: an event was dropped under backpressure
//   hist_count out  [CNT_W-1:0] combinational counter readout
module dice_face_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       led_in,
  input  logic             out_ready,
  input  logic             clear,
  input  logic [2:0]       hist_sel,
  output logic             out_valid,
  output logic [2:0]       out_value,
  output logic             out_error,
  output logic             overrun,
  output logic [CNT_W-1:0] hist_count
);

  localparam logic [7:0] RUN_MAX   = 8'(STABLE_CYCLES);
  localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 1);

  logic [5:0]       led_q;
  logic [5:0]       last_acc;
  logic [7:0]       run_cnt;
  logic             accept;
  logic             new_pat;
  logic             face_legal;
  logic [2:0]       face_val;
  logic             face_ev;
  logic             err_ev;
  logic             ev;
  logic [2:0]       ev_idx;
  logic [CNT_W-1:0] cnt [0:6];

  // The run counter is 1 on the edge that samples a new pattern, so the
  // acceptance edge is the one where it steps from STABLE_CYCLES-1 up to
  // STABLE_CYCLES. It then parks there, so a run accepts at most once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      run_cnt <= '0;
    end else begin
      led_q <= led_in;
      if (led_in != led_q) begin
        run_cnt <= 8'd1;
      end else if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + 8'd1;
      end
    end
  end

  assign accept  = (led_in == led_q) && (run_cnt == ACCEPT_AT);
  assign new_pat = accept && (led_in != last_acc);

  // Face pattern decode; anything not listed (except blank) is illegal.
  always_comb begin
    face_val   = 3'd0;
    face_legal = 1'b1;
    case (led_in)
      6'b000001: face_val = 3'd1;
      6'b000010: face_val = 3'd2;
      6'b000011: face_val = 3'd3;
      6'b001100: face_val = 3'd4;
      6'b001101: face_val = 3'd5;
      6'b111100: face_val = 3'd6;
      default:   face_legal = 1'b0;
    endcase
  end

  // Blank is a legal "no face" pattern: it re-arms change detection but
  // never produces an event.
  assign face_ev = new_pat && face_legal;
  assign err_ev  = new_pat && !face_legal && (led_in != 6'b000000);
  assign ev      = face_ev || err_ev;
  assign ev_idx  = err_ev ? 3'd0 : face_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_acc <= '0;
    end else if (new_pat) begin
      last_acc <= led_in;
    end
  end

  // Single-entry output register. A new event may replace the held one on
  // the same edge it is consumed. If the slot is full and not being drained
  // the new event is dropped and overrun records it; clear wins over a
  // same-cycle overrun so the flag reads as freshly cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_value <= 3'd0;
      out_error <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ev && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_value <= face_val;
        out_error <= err_ev;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clear) begin
        overrun <= 1'b0;
      end else if (ev && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  // Index 0 holds err_count, 1..6 the face counters. Every event counts,
  // including dropped ones; clear takes priority over a same-cycle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (clear) begin
          cnt[i] <= '0;
        end else if (ev && (ev_idx == 3'(i)) && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Select 7 has no counter behind it and reads as zero.
  always_comb begin
    hist_count = '0;
    for (int i = 0; i < 7; i++) begin
      if (hist_sel == 3'(i)) begin
        hist_count = cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_dice_face_decoder.sv
// tb_dice_face_decoder
//   Scoreboard bench for dice_face_decoder. A reference model at each rising
//   edge keeps the recent sample history, decides acceptance from "the last
//   STABLE samples are equal and the one before differs", and pushes each
//   expected event into a queue. A monitor on the falling edge checks the
//   output register, overrun and histogram readout, popping the queue when
//   the consumer takes an event.
module tb_dice_face_decoder;

  localparam int STABLE = 4;
  localparam int CW     = 3;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [5:0]    led_in    = 6'b000000;
  logic          out_ready = 1'b0;
  logic          clear     = 1'b0;
  logic [2:0]    hist_sel  = 3'd0;
  logic          out_valid;
  logic [2:0]    out_value;
  logic          out_error;
  logic          overrun;
  logic [CW-1:0] hist_count;

  dice_face_decoder #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_in    (led_in),
    .out_ready (out_ready),
    .clear     (clear),
    .hist_sel  (hist_sel),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_error (out_error),
    .overrun   (overrun),
    .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] value;
    logic       err;
  } ev_t;

  int         compared   = 0;
  int         mismatched = 0;
  ev_t        exp_q[$];
  logic [5:0] samples[$];
  int         model_cnt[7];
  logic [5:0] model_last;
  bit         model_overrun;

  // Face value of a pattern by table lookup, 0 if it is not a face.
  function automatic int face_of(input logic [5:0] p);
    logic [5:0] enc [0:5];
    enc[0] = 6'b000001;
    enc[1] = 6'b000010;
    enc[2] = 6'b000011;
    enc[3] = 6'b001100;
    enc[4] = 6'b001101;
    enc[5] = 6'b111100;
    for (int i = 0; i < 6; i++) begin
      if (p == enc[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model, evaluated with the inputs present at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      samples.delete();
      for (int i = 0; i < 7; i++) model_cnt[i] = 0;
      model_last    = 6'b000000;
      model_overrun = 1'b0;
    end else begin
      bit         accepted;
      bit         is_ev;
      int         idx;
      int         n;
      logic [5:0] pat;
      ev_t        e;

      samples.push_back(led_in);
      if (samples.size() > STABLE + 1) void'(samples.pop_front());
      n        = samples.size();
      pat      = samples[n-1];
      accepted = 1'b0;
      is_ev    = 1'b0;
      idx      = 0;
      if (n >= STABLE) begin
        accepted = 1'b1;
        for (int k = n - STABLE; k < n; k++) begin
          if (samples[k] != pat) accepted = 1'b0;
        end
        if (n == STABLE + 1 && samples[0] == pat) accepted = 1'b0;
      end
      if (accepted && pat != model_last) begin
        model_last = pat;
        if (pat != 6'b000000) begin
          is_ev = 1'b1;
          idx   = face_of(pat);
        end
      end

      if (clear) begin
        for (int i = 0; i < 7; i++) model_cnt[i] = 0;
        model_overrun = 1'b0;
      end else if (is_ev && model_cnt[idx] < CMAX) begin
        model_cnt[idx] = model_cnt[idx] + 1;
      end

      // A non-empty queue here means the held event was not consumed.
      if (is_ev) begin
        if (exp_q.size() == 0) begin
          e.value = 3'(idx);
          e.err   = (idx == 0);
          exp_q.push_back(e);
        end else if (!clear) begin
          model_overrun = 1'b1;
        end
      end
    end
  end

  // Monitor, sampling half a cycle after each rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_value", int'(out_value), 0);
      checkOutput("reset out_error", int'(out_error), 0);
      checkOutput("reset overrun", int'(overrun), 0);
      checkOutput("reset hist_count", int'(hist_count), 0);
    end else begin
      ev_t e;
      checkOutput("out_valid", int'(out_valid), (exp_q.size() > 0) ? 1 : 0);
      checkOutput("overrun", int'(overrun), int'(model_overrun));
      checkOutput("hist_count", int'(hist_count),
                  (hist_sel == 3'd7) ? 0 : model_cnt[hist_sel]);
      if (exp_q.size() > 0 && out_ready) begin
        e = exp_q.pop_front();
        checkOutput("out_value", int'(out_value), int'(e.value));
        checkOutput("out_error", int'(out_error), int'(e.err));
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] pat, input int cycles,
                               input int ready_pct, input int clear_permille);
    repeat (cycles) begin
      @(posedge clk);
      #2;
      led_in    = pat;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      clear     = ($urandom_range(0, 999) < clear_permille);
      hist_sel  = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic applyReset(input int cycles);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_pattern();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 6'b000001;
      1: return 6'b000010;
      2: return 6'b000011;
      3: return 6'b001100;
      4: return 6'b001101;
      5: return 6'b111100;
      6, 7: return 6'b000000;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    $display("[TB] dice_face_decoder bench, STABLE=%0d CNT_W=%0d", STABLE, CW);
    led_in    = 6'b001101;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Face 5 straight out of reset, then the face/blank/glitch/illegal cases.
    applyStimulus(6'b001101, 6, 100, 0);
    applyStimulus(6'b000011, 6, 100, 0);
    applyStimulus(6'b000000, 5, 100, 0);
    applyStimulus(6'b000011, 6, 100, 0);
    applyStimulus(6'b001100, 3, 100, 0);
    applyStimulus(6'b001101, 6, 100, 0);
    applyStimulus(6'b010101, 6, 100, 0);

    // Backpressure: face 1 held, face 2 dropped, then drain.
    applyStimulus(6'b000001, 5, 0, 0);
    applyStimulus(6'b000000, 5, 0, 0);
    applyStimulus(6'b000010, 6, 0, 0);
    applyStimulus(6'b000010, 3, 100, 0);

    // Face 6 / blank alternations drive the 6 counter into saturation,
    // then a face 6 settles with clear held.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(6'b111100, 5, 100, 0);
      applyStimulus(6'b000000, 5, 100, 0);
    end
    applyStimulus(6'b111100, 6, 100, 1000);

    // Randomised traffic with a mid-run reset.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(pick_pattern(), $urandom_range(1, 8), 70, 4);
      if (i == 150) applyReset(3);
    end

    applyStimulus(6'b000000, 8, 100, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dice_face_decoder.md
# dice_face_decoder

Receive-side companion to the dice roller display. Samples the 6-bit LED face pattern driven by a roller, filters it for stability, decodes each newly settled face to a value 1–6, flags illegal patterns, and presents each event on a single-entry valid/ready output. Keeps saturating per-face and error histograms for statistics readout. Sits between a roller's LED bus and a host or statistics consumer in the same clock domain.

## Interface
- STABLE_CYCLES, 4, consecutive sampling edges a pattern must hold before it is accepted; legal range is 2 to 255.
- CNT_W, 16, width of each histogram and error counter.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- led_in  in  6  face pattern from the roller, synchronous to clk
- out_ready  in  1  consumer accepts the output event this cycle
- clear  in  1  synchronous clear of histograms, err_count and overrun
- hist_sel  in  3  histogram read select
- out_valid  out  1  an output event is held
- out_value  out  3  decoded face 1–6; 0 when out_error=1
- out_error  out  1  the held event is an illegal pattern
- overrun  out  1  sticky flag: an event was dropped because of backpressure
- hist_count  out  CNT_W  combinational readout of the selected counter

## Operation
- Encoding: 1=000001, 2=000010, 3=000011, 4=001100, 5=001101, 6=111100. 000000 is blank. Every other pattern is illegal.
- Stability filter: led_q captures led_in on every edge.
  - The run counter (8 bits) loads 1 when led_in≠led_q.
  - Otherwise it increments, saturating at STABLE_CYCLES.
  - A pattern is accepted on the edge where the run counter goes from STABLE_CYCLES−1 to STABLE_CYCLES. A run accepts at most once.
- Change detect: an accepted pattern equal to last_acc produces nothing. Otherwise last_acc is loaded with it.
  - If that pattern is blank, no event is produced.
  - If it is a legal face, a face event is produced.
  - If it is illegal, an error event is produced.
- Output register:
  - An event loads out_value/out_error and sets out_valid when out_valid=0, or when out_valid=1 and out_ready=1 (same-edge replace).
  - out_valid clears on out_valid and out_ready with no new event.
  - An event arriving while out_valid=1 and out_ready=0 is dropped, the held event is unchanged, and overrun is set.
- Histograms: six face counters plus err_count.
  - Each event increments its counter regardless of handshake state, including dropped events.
  - Counters saturate at 2^CNT_W−1.
- Readout: hist_sel 1–6 returns the face counter, 0 returns err_count, 7 returns 0.
- clear: zeros all counters and overrun. It has priority over a same-cycle increment, so that event is not counted. clear does not affect out_valid, the output register, last_acc or the filter.

## Timing
- Reset values:
  - out_valid=0, out_value=0, out_error=0, overrun=0.
  - All counters, led_q, last_acc and the run counter are 0.
  - hist_count=0.
- Latency: let E0 be the first edge sampling a new pattern P, held constant.
  - The event registers at edge E(STABLE_CYCLES−1).
  - out_valid is high in the cycle after that edge.
  - The histogram is incremented at the same edge.
- A change of led_in before acceptance restarts the run. The intermediate pattern never produces an event.
- Blank between two identical faces re-arms change detect: 3, blank, 3 gives two events.
- After reset, a constant 000000 input is accepted as blank and produces no event.
- rst_n asserted mid-run or mid-handshake: all state returns to reset values immediately, and the pending event is lost.
- hist_count is combinational from registered counters, valid in the same cycle as hist_sel.

## Test plan
- Reset: hold rst_n=0 with led_in=001101 -> all outputs 0. Release and hold 001101 for 4 edges -> out_valid=1, out_value=5 after the 4th edge.
- Basic face with STABLE_CYCLES=4 and out_ready=1: led_in=000011 for 6 cycles -> out_valid high exactly 1 cycle with out_value=3, out_error=0. hist_sel=3 reads 1. Continued holding produces no second event.
- Glitch reject: 001100 for 3 cycles then 001101 for 4 cycles -> a single event with value 5. hist 4=0, hist 5=1.
- Illegal pattern: 010101 held 4 cycles -> out_error=1, out_value=0. hist_sel=0 reads 1.
- Backpressure: out_ready=0, then face 1 settles, blank, face 2 settles -> output holds value 1, overrun=1, hist 1=1 and hist 2=1. Then out_ready=1 for 1 cycle -> out_valid=0.
- Saturation/clear with CNT_W=2: five 6/blank alternations -> hist 6 reads 3. clear asserted in the same cycle as a 6 event -> hist 6 reads 0 and overrun=0, while the event still appears on out_value=6.
